// File: rtl/vga_line_prefetch.sv
// VGA line prefetcher: fetches each active line from frame memory into a
// ping-pong line buffer one line ahead of display and serves RGB pixels with
// one cycle of latency.
module vga_line_prefetch #(
  parameter int unsigned H_ACT       = 640,
  parameter int unsigned V_ACT       = 480,
  parameter int unsigned Y_START     = 35,
  parameter int unsigned ADDR_W      = 22,
  parameter int unsigned FB_BASE     = 0,
  parameter int unsigned LINE_STRIDE = 1024,
  parameter int unsigned MAX_OUTST   = 8
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [11:0]       iRequestX,
  input  logic [11:0]       iRequestY,
  input  logic [11:0]       iVCounter,
  output logic [7:0]        oRed,
  output logic [7:0]        oGreen,
  output logic [7:0]        oBlue,
  output logic              oMemReq,
  output logic [ADDR_W-1:0] oMemAddr,
  input  logic              iMemGnt,
  input  logic              iMemRdValid,
  input  logic [23:0]       iMemRdData,
  output logic              oBusy,
  output logic              oUnderrun
);

  localparam int unsigned XW = $clog2(H_ACT);
  localparam int unsigned CW = $clog2(H_ACT + 1);
  localparam int unsigned LW = (V_ACT > 1) ? $clog2(V_ACT) : 1;
  localparam int unsigned OW = $clog2(MAX_OUTST + 1);
  localparam logic [11:0] V_LO = 12'(Y_START - 1);
  localparam logic [11:0] V_HI = 12'(Y_START - 1 + V_ACT);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t          state, state_n;
  logic [11:0]     vprev;
  logic [LW-1:0]   line;
  logic [CW-1:0]   icnt, wcnt;
  logic [OW-1:0]   outst;
  logic            discard;
  logic            underrun;
  logic [23:0]     rgb;
  logic [23:0]     lbuf [2][H_ACT];

  logic            trig, mem_req, issue, rd_ret, wr_en;
  logic            start, abort, restart;
  logic [LW-1:0]   trig_line;
  logic            unused_ry;

  assign trig      = (iVCounter != vprev) && (iVCounter >= V_LO) && (iVCounter < V_HI);
  assign trig_line = LW'(iVCounter - V_LO);
  assign mem_req   = (state == REQ) && (icnt < CW'(H_ACT)) && (outst < OW'(MAX_OUTST));
  assign issue     = mem_req & iMemGnt;
  assign rd_ret    = iMemRdValid && (outst != '0);
  assign wr_en     = rd_ret && !discard && (state != IDLE) && (wcnt < CW'(H_ACT));
  assign unused_ry = ^iRequestY[11:1];

  // FSM state register
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state: a trigger while busy aborts into a discarding drain; once
  // nothing is in flight the drain restarts the fetch for the new line.
  always_comb begin
    state_n = state;
    start   = 1'b0;
    abort   = 1'b0;
    restart = 1'b0;
    unique case (state)
      IDLE: begin
        if (trig) begin
          state_n = REQ;
          start   = 1'b1;
        end
      end
      REQ: begin
        if (trig) begin
          state_n = DRAIN;
          abort   = 1'b1;
        end else if (icnt == CW'(H_ACT)) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (trig) begin
          abort = 1'b1;
        end else if (discard) begin
          if (outst == '0) begin
            state_n = REQ;
            restart = 1'b1;
          end
        end else if (wcnt == CW'(H_ACT)) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Fetch bookkeeping: line select, issue/write counters, in-flight count
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      vprev    <= '0;
      line     <= '0;
      icnt     <= '0;
      wcnt     <= '0;
      outst    <= '0;
      discard  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      vprev    <= iVCounter;
      outst    <= outst + OW'(issue) - OW'(rd_ret);
      underrun <= underrun | abort;
      if (start || abort) line <= trig_line;
      if (abort)        discard <= 1'b1;
      else if (restart) discard <= 1'b0;
      if (start || restart) begin
        icnt <= '0;
        wcnt <= '0;
      end else begin
        if (issue) icnt <= icnt + CW'(1);
        if (wr_en) wcnt <= wcnt + CW'(1);
      end
    end
  end

  // Line buffer write port (bank chosen by target line parity)
  always_ff @(posedge iCLK) begin
    if (wr_en) lbuf[line[0]][wcnt[XW-1:0]] <= iMemRdData;
  end

  // Registered pixel readout; columns past the active width read as black
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST)                      rgb <= '0;
    else if (iRequestX < 12'(H_ACT)) rgb <= lbuf[iRequestY[0]][iRequestX[XW-1:0]];
    else                            rgb <= '0;
  end

  assign oMemAddr  = ADDR_W'(FB_BASE) + ADDR_W'(line) * ADDR_W'(LINE_STRIDE) + ADDR_W'(icnt);
  assign oMemReq   = mem_req;
  assign oBusy     = (state != IDLE);
  assign oUnderrun = underrun;
  assign oRed      = rgb[23:16];
  assign oGreen    = rgb[15:8];
  assign oBlue     = rgb[7:0];

endmodule

// File: tb/tb_vga_line_prefetch.sv
// Bench for vga_line_prefetch: memory responder plus a line-level model of
// what each bank should hold and which addresses each fetch must issue.
module tb_vga_line_prefetch;
  localparam int unsigned H    = 640;
  localparam int unsigned MAXO = 8;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic [11:0] iRequestX = '0, iRequestY = '0, iVCounter = '0;
  logic [7:0]  oRed, oGreen, oBlue;
  logic        oMemReq;
  logic [21:0] oMemAddr;
  logic        iMemGnt = 1'b0, iMemRdValid = 1'b0;
  logic [23:0] iMemRdData = '0;
  logic        oBusy, oUnderrun;

  always #5 iCLK = ~iCLK;

  vga_line_prefetch #(
    .H_ACT(640), .V_ACT(480), .Y_START(35), .ADDR_W(22),
    .FB_BASE(0), .LINE_STRIDE(1024), .MAX_OUTST(8)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iRequestX(iRequestX), .iRequestY(iRequestY),
    .iVCounter(iVCounter), .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
    .oMemReq(oMemReq), .oMemAddr(oMemAddr), .iMemGnt(iMemGnt),
    .iMemRdValid(iMemRdValid), .iMemRdData(iMemRdData),
    .oBusy(oBusy), .oUnderrun(oUnderrun)
  );

  int unsigned checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory model state
  typedef struct {
    int unsigned gen;
    logic [21:0] addr;
    int unsigned due;
  } ent_t;
  ent_t q[$];

  int unsigned cyc = 0, m_gen = 0, m_line = 0, exp_i = 0, m_w = 0, issues = 0;
  int unsigned done_age = 1000, lat = 3, prev_vc = 0, max_q = 0, gnt_mode = 0;
  int unsigned lw [2];
  bit          m_active = 0, m_under = 0, abort_chk = 0, prev_req = 0, prev_gnt = 0, exp_v = 0;
  logic [21:0] prev_addr = '0, first_addr = '0, last_addr = '0;
  logic [23:0] exp_rgb = '0;
  logic [11:0] rd_x = '0, rd_y = '0;
  logic [23:0] mb [2][H];
  bit          mk [2][H];

  function automatic logic [23:0] mdat(input logic [21:0] a);
    if (a == 22'd5) return 24'h123456;
    return {a[7:0], a[15:8] ^ 8'h3C, {2'b00, a[21:16]} ^ 8'h5A};
  endfunction

  task automatic clear_model();
    q.delete();
    m_active = 0; m_under = 0; abort_chk = 0; prev_req = 0; prev_gnt = 0;
    exp_v = 0; done_age = 1000; prev_vc = 0; iMemRdValid = 0;
    lw[0] = 0; lw[1] = 0;
    for (int b = 0; b < 2; b++)
      for (int x = 0; x < int'(H); x++) mk[b][x] = 0;
  endtask

  // One clock: check outputs, act as memory, then present the next pixel request.
  task automatic tick();
    int   bk;
    ent_t e;
    logic [23:0] d;
    @(negedge iCLK);
    cyc++;
    if (exp_v) chk("rgb", 32'({oRed, oGreen, oBlue}), 32'(exp_rgb));
    chk("underrun", 32'(oUnderrun), 32'(m_under));
    if (m_active) chk("busy", 32'(oBusy), 1);
    else if (done_age >= 2) chk("idle", 32'(oBusy), 0);
    if (abort_chk) begin
      chk("req_drop", 32'(oMemReq), 0);
      abort_chk = 0;
    end else if (prev_req && !prev_gnt) begin
      chk("req_hold", 32'(oMemReq), 1);
      chk("addr_hold", 32'(oMemAddr), 32'(prev_addr));
    end
    case (gnt_mode)
      0:       iMemGnt = 1'b1;
      1:       iMemGnt = (cyc % 2 == 0);
      default: iMemGnt = 1'b0;
    endcase
    if (oMemReq && iMemGnt) begin
      chk("issue_in_fetch", 32'(m_active && exp_i < H), 1);
      if (q.size() > 0) chk("issue_before_drain", q[0].gen, m_gen);
      chk("addr", 32'(oMemAddr), 32'(22'(m_line * 1024 + exp_i)));
      if (exp_i == 0) first_addr = oMemAddr;
      last_addr = oMemAddr;
      exp_i++; issues++;
      e.gen = m_gen; e.addr = oMemAddr; e.due = cyc + lat;
      q.push_back(e);
    end
    if (q.size() > 0 && q[0].due <= cyc) begin
      d = mdat(q[0].addr);
      iMemRdValid = 1'b1;
      iMemRdData  = d;
      if (q[0].gen == m_gen && m_active) begin
        bk = int'(m_line % 2);
        mb[bk][m_w] = d; mk[bk][m_w] = 1; lw[bk] = cyc;
        m_w++;
        if (m_w == H) begin m_active = 0; done_age = 0; end
      end
      void'(q.pop_front());
    end else begin
      iMemRdValid = 1'b0;
      iMemRdData  = '0;
    end
    if (q.size() > max_q) max_q = q.size();
    chk("outst_le_max", 32'(q.size() <= MAXO), 1);
    prev_req = oMemReq; prev_gnt = iMemGnt; prev_addr = oMemAddr;
    if (!m_active && done_age < 1000) done_age++;
    iRequestX = rd_x; iRequestY = rd_y;
    bk = int'(rd_y[0]);
    if (rd_x >= 12'(H)) begin exp_v = 1; exp_rgb = '0; end
    else if (mk[bk][rd_x] && lw[bk] != cyc) begin exp_v = 1; exp_rgb = mb[bk][rd_x]; end
    else exp_v = 0;
  endtask

  task automatic set_vc(input logic [11:0] v);
    if (32'(v) != prev_vc && v >= 12'd34 && v < 12'd514) begin
      if (m_active) begin m_under = 1; abort_chk = 1; end
      m_gen++; m_line = 32'(v) - 34; exp_i = 0; m_w = 0; m_active = 1; issues = 0;
    end
    prev_vc = 32'(v);
    iVCounter = v;
  endtask

  task automatic wait_done(input int limit, input string nm);
    int n = 0;
    while (!(!m_active && done_age >= 3) && n < limit) begin
      rd_x = 12'((cyc * 7) % 660);
      tick();
      n++;
    end
    chk(nm, 32'(n < limit), 1);
  endtask

  task automatic sweep(input logic [11:0] y);
    rd_y = y;
    for (int x = 0; x < 650; x++) begin
      rd_x = 12'(x);
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_model();
    repeat (2) @(negedge iCLK);
    chk("rst_req",   32'(oMemReq), 0);
    chk("rst_busy",  32'(oBusy), 0);
    chk("rst_under", 32'(oUnderrun), 0);
    chk("rst_rgb",   32'({oRed, oGreen, oBlue}), 0);
    chk("rst_addr",  32'(oMemAddr), 0);
    iRST = 1'b1;

    // 1: line 0 into bank 0
    set_vc(12'd33); repeat (3) tick();
    set_vc(12'd34);
    wait_done(2000, "t1_done");
    chk("t1_issues", issues, 640);
    chk("t1_first", 32'(first_addr), 0);
    chk("t1_last", 32'(last_addr), 639);

    // 2: readout literals, then full bank 0 sweep
    rd_y = 12'd0; rd_x = 12'd5; tick();
    rd_x = 12'd700; tick();
    chk("t2_red", 32'(oRed), 32'h12);
    chk("t2_green", 32'(oGreen), 32'h34);
    chk("t2_blue", 32'(oBlue), 32'h56);
    tick();
    chk("t2_xoor", 32'({oRed, oGreen, oBlue}), 0);
    sweep(12'd0);

    // 3: line 1 into bank 1 while bank 0 is read
    rd_y = 12'd0;
    set_vc(12'd35);
    wait_done(2000, "t3_done");
    chk("t3_issues", issues, 640);
    chk("t3_first", 32'(first_addr), 1024);
    chk("t3_last", 32'(last_addr), 1663);
    sweep(12'd3);

    // 4: grant withheld, then slow memory
    gnt_mode = 2; rd_y = 12'd1;
    set_vc(12'd36);
    tick();
    chk("t4_req", 32'(oMemReq), 1);
    chk("t4_addr", 32'(oMemAddr), 2048);
    repeat (19) tick();
    chk("t4_no_issue", issues, 0);
    gnt_mode = 0; lat = 30; max_q = 0;
    wait_done(6000, "t4_done");
    chk("t4_maxq", max_q, 8);
    chk("t4_issues", issues, 640);

    // 5: half-rate grant, trigger mid-fetch
    lat = 3; gnt_mode = 1; rd_y = 12'd0;
    set_vc(12'd37);
    repeat (60) tick();
    set_vc(12'd38);
    tick();
    chk("t5_under", 32'(oUnderrun), 1);
    wait_done(4000, "t5_done");
    chk("t5_issues", issues, 640);
    chk("t5_first", 32'(first_addr), 4096);
    chk("t5_last", 32'(last_addr), 4735);
    sweep(12'd0);
    sweep(12'd1);

    // 6: window edges, wrap, reset mid-fetch
    gnt_mode = 0;
    set_vc(12'd513);
    wait_done(2000, "t6_done");
    chk("t6_first", 32'(first_addr), 490496);
    set_vc(12'd514); repeat (10) tick();
    chk("t6_514_idle", 32'(oBusy), 0);
    set_vc(12'd524); tick();
    set_vc(12'd0); repeat (10) tick();
    chk("t6_wrap_idle", 32'(oBusy), 0);
    chk("t6_wrap_issues", issues, 640);
    set_vc(12'd34); repeat (40) tick();
    chk("t6_busy", 32'(oBusy), 1);
    iRST = 1'b0;
    #1;
    chk("t6_rst_req", 32'(oMemReq), 0);
    chk("t6_rst_busy", 32'(oBusy), 0);
    chk("t6_rst_under", 32'(oUnderrun), 0);
    chk("t6_rst_rgb", 32'({oRed, oGreen, oBlue}), 0);
    clear_model();
    iVCounter = 12'd0;
    @(negedge iCLK);
    iRST = 1'b1;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
